// File: rtl/alu_preg.sv
// Post-mux ALU stage: ALUMODE-selected add/subtract of X, Y, Z plus carry-in,
// with optional ALUMODE/CARRYIN input registers and an optional P output register.
module alu_preg #(
    parameter int unsigned PREG       = 1,
    parameter int unsigned ALUMODEREG = 1,
    parameter int unsigned CARRYINREG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cep,
    input  logic        cealumode,
    input  logic        cecarryin,
    input  logic [47:0] x,
    input  logic [47:0] y,
    input  logic [47:0] z,
    input  logic [3:0]  alumode,
    input  logic        carryin,
    output logic [47:0] p,
    output logic        carryout,
    output logic        alumode_err
);

    logic [3:0]  am;
    logic        ci;
    logic [49:0] s;
    logic [49:0] zs;
    logic [49:0] nzs;
    logic [47:0] dif;
    logic [47:0] r_p;
    logic        r_co;
    logic        r_err;

    generate
        if (ALUMODEREG != 0) begin : g_amreg
            logic [3:0] alumode_q;
            always_ff @(posedge clk) begin
                if (rst)
                    alumode_q <= 4'b0000;
                else if (cealumode)
                    alumode_q <= alumode;
            end
            assign am = alumode_q;
        end else begin : g_amcomb
            assign am = alumode;
        end

        if (CARRYINREG != 0) begin : g_cireg
            logic carryin_q;
            always_ff @(posedge clk) begin
                if (rst)
                    carryin_q <= 1'b0;
                else if (cecarryin)
                    carryin_q <= carryin;
            end
            assign ci = carryin_q;
        end else begin : g_cicomb
            assign ci = carryin;
        end
    endgenerate

    // 50-bit sums: x + y + z + 1 peaks below 3 * 2^48, so nothing is truncated.
    assign s   = {2'b00, x} + {2'b00, y} + {49'd0, ci};
    assign zs  = {2'b00, z} + s;
    assign nzs = {2'b00, ~z} + s;
    // Low 48 bits of z - s are exact modulo 2^48; the borrow comes from the full compare.
    assign dif = z - s[47:0];

    always_comb begin
        r_p   = zs[47:0];
        r_co  = |zs[49:48];
        r_err = 1'b0;
        case (am)
            4'b0000: begin
            end
            4'b0011: begin
                r_p  = dif;
                r_co = ({2'b00, z} >= s);
            end
            4'b0001: begin
                r_p  = nzs[47:0];
                r_co = |nzs[49:48];
            end
            4'b0010: begin
                r_p  = ~zs[47:0];
                r_co = |zs[49:48];
            end
            default: begin
                r_err = 1'b1;
            end
        endcase
    end

    generate
        if (PREG != 0) begin : g_preg
            always_ff @(posedge clk) begin
                if (rst) begin
                    p           <= 48'd0;
                    carryout    <= 1'b0;
                    alumode_err <= 1'b0;
                end else if (cep) begin
                    p           <= r_p;
                    carryout    <= r_co;
                    alumode_err <= r_err;
                end
            end
        end else begin : g_pcomb
            assign p           = r_p;
            assign carryout    = r_co;
            assign alumode_err = r_err;
        end
    endgenerate

endmodule

// File: tb/tb_alu_preg.sv
// Self-checking bench for alu_preg with all registers present: vector table plus
// hand sequences for enables, reset, mode-change alignment and accumulation.
module tb_alu_preg;

    logic        clk = 1'b0;
    logic        rst;
    logic        cep;
    logic        cealumode;
    logic        cecarryin;
    logic [47:0] x;
    logic [47:0] y;
    logic [47:0] z_tb;
    logic [47:0] z;
    logic [3:0]  alumode;
    logic        carryin;
    logic [47:0] p;
    logic        carryout;
    logic        alumode_err;
    logic        acc_mode;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  am;
        logic        ci;
        logic [47:0] x;
        logic [47:0] y;
        logic [47:0] z;
        logic [47:0] ep;
        logic        eco;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [47:0] p;
        logic        co;
        logic        err;
        string       tag;
    } exp_t;

    vec_t vecs[14];
    exp_t sbq[$];

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    assign z = acc_mode ? p : z_tb;

    alu_preg #(.PREG(1), .ALUMODEREG(1), .CARRYINREG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cep        (cep),
        .cealumode  (cealumode),
        .cecarryin  (cecarryin),
        .x          (x),
        .y          (y),
        .z          (z),
        .alumode    (alumode),
        .carryin    (carryin),
        .p          (p),
        .carryout   (carryout),
        .alumode_err(alumode_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [47:0] ep, input logic eco, input logic eerr, input string tag);
        exp_t e;
        e.p   = ep;
        e.co  = eco;
        e.err = eerr;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: empty queue at compare time, got p=%h", p);
        end else begin
            e = sbq.pop_front();
            chk({e.tag, ".p"}, p, e.p);
            chk({e.tag, ".co"}, {47'd0, carryout}, {47'd0, e.co});
            chk({e.tag, ".err"}, {47'd0, alumode_err}, {47'd0, e.err});
        end
    endtask

    // Reference accumulate step for am=0000 with ci=0: 64-bit sum, wrap at 2^48.
    function automatic logic [48:0] acc_step(input logic [47:0] a, input logic [47:0] b);
        longint unsigned t;
        t = longint'(a) + longint'(b);
        return {t >= 64'h1_0000_0000_0000, t[47:0]};
    endfunction

    initial begin
        logic [48:0] r;
        logic [47:0] acc;

        vecs[0]  = '{4'b0000, 1'b1, 48'd1,  48'd2, 48'd3,  48'd7,  1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 48'd1,  48'd0, ONES,   48'd0,  1'b1, 1'b0};
        vecs[2]  = '{4'b0011, 1'b0, 48'd3,  48'd0, 48'd10, 48'd7,  1'b1, 1'b0};
        vecs[3]  = '{4'b0011, 1'b0, 48'd10, 48'd0, 48'd3,  48'hFFFF_FFFF_FFF9, 1'b0, 1'b0};
        vecs[4]  = '{4'b0001, 1'b0, 48'd10, 48'd0, 48'd3,  48'd6,  1'b1, 1'b0};
        vecs[5]  = '{4'b0010, 1'b0, 48'd1,  48'd0, 48'd1,  48'hFFFF_FFFF_FFFD, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 1'b0, 48'd2,  48'd2, 48'd2,  48'd6,  1'b0, 1'b1};
        vecs[7]  = '{4'b0000, 1'b0, 48'd2,  48'd2, 48'd2,  48'd6,  1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b1, ONES,   ONES,  ONES,   48'hFFFF_FFFF_FFFE, 1'b1, 1'b0};
        vecs[9]  = '{4'b0011, 1'b1, 48'd0,  48'd0, 48'd0,  ONES,   1'b0, 1'b0};
        vecs[10] = '{4'b0011, 1'b0, 48'd5,  48'd0, 48'd5,  48'd0,  1'b1, 1'b0};
        vecs[11] = '{4'b0001, 1'b0, 48'd0,  48'd0, 48'd0,  ONES,   1'b0, 1'b0};
        vecs[12] = '{4'b0010, 1'b0, 48'd1,  48'd0, ONES,   ONES,   1'b1, 1'b0};
        vecs[13] = '{4'b1111, 1'b0, 48'd1,  48'd1, 48'd1,  48'd3,  1'b0, 1'b1};

        acc_mode  = 1'b0;
        rst       = 1'b1;
        cep       = 1'b1;
        cealumode = 1'b1;
        cecarryin = 1'b1;
        alumode   = 4'b0000;
        carryin   = 1'b0;
        x         = 48'h123;
        y         = 48'h123;
        z_tb      = 48'h123;

        // Reset with cep high, then release
        tick();
        push(48'd0, 1'b0, 1'b0, "reset");
        pop_check();
        rst = 1'b0;
        tick();
        push(48'h369, 1'b0, 1'b0, "release1");
        pop_check();
        tick();
        push(48'h369, 1'b0, 1'b0, "release2");
        pop_check();

        // Table: hold mode/carry for two edges so the registered operands settle
        for (int i = 0; i < 14; i++) begin
            alumode = vecs[i].am;
            carryin = vecs[i].ci;
            x       = vecs[i].x;
            y       = vecs[i].y;
            z_tb    = vecs[i].z;
            push(vecs[i].ep, vecs[i].eco, vecs[i].eerr, $sformatf("vec%0d", i));
            tick();
            tick();
            pop_check();
        end

        // cep low: P holds while operands change
        alumode = 4'b0000;
        carryin = 1'b0;
        x = 48'd1; y = 48'd1; z_tb = 48'd1;
        tick();
        tick();
        push(48'd3, 1'b0, 1'b0, "pre_hold");
        pop_check();
        cep = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x    = {16'($urandom), $urandom};
            y    = {16'($urandom), $urandom};
            z_tb = {16'($urandom), $urandom};
            tick();
            push(48'd3, 1'b0, 1'b0, $sformatf("hold%0d", i));
            pop_check();
        end

        // cealumode low: a new alumode must not reach the ALU
        cep = 1'b1;
        cealumode = 1'b0;
        alumode = 4'b0011;
        x = 48'd1; y = 48'd1; z_tb = 48'd1;
        tick();
        tick();
        push(48'd3, 1'b0, 1'b0, "am_hold");
        pop_check();

        // Mode change and capture on the same edge: old am used first
        cealumode = 1'b1;
        alumode   = 4'b0000;
        tick();
        x = 48'd4; y = 48'd0; z_tb = 48'd10;
        alumode = 4'b0011;
        tick();
        push(48'd14, 1'b0, 1'b0, "am_old");
        pop_check();
        tick();
        push(48'd6, 1'b1, 1'b0, "am_new");
        pop_check();

        // Carry-in register load then hold
        alumode = 4'b0000;
        carryin = 1'b1;
        x = 48'd0; y = 48'd0; z_tb = 48'd0;
        tick();
        cecarryin = 1'b0;
        carryin   = 1'b0;
        tick();
        push(48'd1, 1'b0, 1'b0, "ci_load");
        pop_check();
        tick();
        push(48'd1, 1'b0, 1'b0, "ci_hold");
        pop_check();

        // Reset clears the input registers even with their enables low
        cealumode = 1'b1;
        alumode   = 4'b0011;
        tick();
        cealumode = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x = 48'd2; y = 48'd0; z_tb = 48'd5;
        tick();
        push(48'd7, 1'b0, 1'b0, "rst_regs");
        pop_check();

        // Accumulate with Z fed from P
        cealumode = 1'b1;
        cecarryin = 1'b1;
        alumode   = 4'b0000;
        carryin   = 1'b0;
        acc_mode  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x = 48'd5; y = 48'd0;
        acc = 48'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            r = acc_step(acc, 48'd5);
            acc = r[47:0];
            push(acc, r[48], 1'b0, $sformatf("acc%0d", i));
            pop_check();
        end
        rst = 1'b1;
        tick();
        acc = 48'd0;
        push(acc, 1'b0, 1'b0, "acc_rst");
        pop_check();
        rst = 1'b0;
        tick();
        r = acc_step(acc, 48'd5);
        acc = r[47:0];
        push(acc, r[48], 1'b0, "acc_restart");
        pop_check();

        // Wrap-around sets carryout for one cycle only
        x = 48'hFFFF_FFFF_FFF9;
        tick();
        r = acc_step(acc, 48'hFFFF_FFFF_FFF9);
        acc = r[47:0];
        push(acc, r[48], 1'b0, "acc_top");
        pop_check();
        x = 48'd3;
        tick();
        r = acc_step(acc, 48'd3);
        acc = r[47:0];
        push(acc, r[48], 1'b0, "acc_wrap");
        pop_check();
        x = 48'd1;
        tick();
        r = acc_step(acc, 48'd1);
        acc = r[47:0];
        push(acc, r[48], 1'b0, "acc_after");
        pop_check();

        n_checks++;
        if (sbq.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
